// File: rtl/missile_pkg.sv
// +-----------------------------------------------------------------------------
// | Module      : missile_pkg
// | Description : Shared types and default parameters for the missile scheduler.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package missile_pkg;

    localparam int c_def_num_slots = 4;
    localparam int c_def_lifetime  = 60;
    localparam int c_def_cooldown  = 8;
    localparam int c_life_w        = 8;
    localparam int c_cd_w          = 5;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_LAUNCH = 2'd1,
        SLOT_FLIGHT = 2'd2
    } slot_state_t;

    typedef enum logic {
        PLAYER_0 = 1'b0,
        PLAYER_1 = 1'b1
    } player_t;

endpackage

`default_nettype wire

// File: rtl/missile_slot.sv
// +-----------------------------------------------------------------------------
// | Module      : missile_slot
// | Description : One missile slot: IDLE/LAUNCH/FLIGHT FSM with lifetime counter.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module missile_slot
    import missile_pkg::*;
#(
    parameter int LIFETIME = c_def_lifetime
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    grant,
    input  player_t grant_owner,
    input  logic    kill,
    output logic    launch,
    output logic    active,
    output player_t owner
);

    slot_state_t         state_q, state_d;
    logic [c_life_w-1:0] life_q, life_d;
    player_t             owner_q, owner_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_IDLE;
            life_q  <= '0;
            owner_q <= PLAYER_0;
        end else begin
            state_q <= state_d;
            life_q  <= life_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        life_d  = life_q;
        owner_d = owner_q;
        case (state_q)
            SLOT_IDLE: begin
                if (grant) begin
                    state_d = SLOT_LAUNCH;
                    life_d  = c_life_w'(LIFETIME);
                    owner_d = grant_owner;
                end
            end
            SLOT_LAUNCH: begin
                state_d = kill ? SLOT_IDLE : SLOT_FLIGHT;
            end
            SLOT_FLIGHT: begin
                // Kill and expiry landing together collapse into one return to IDLE.
                if (kill || (life_q == '0)) begin
                    state_d = SLOT_IDLE;
                    life_d  = '0;
                end else begin
                    life_d = life_q - c_life_w'(1);
                end
            end
            default: begin
                state_d = SLOT_IDLE;
            end
        endcase
    end

    assign launch = (state_q == SLOT_LAUNCH);
    assign active = (state_q != SLOT_IDLE);
    assign owner  = owner_q;

endmodule

`default_nettype wire

// File: rtl/missile_sched.sv
// +-----------------------------------------------------------------------------
// | Module      : missile_sched
// | Description : Two-player missile slot arbiter with cooldowns and round-robin.
// |               Define MISSILE_SCHED_PLAYER_CAP_EN to cap each player at
// |               NUM_SLOTS/2 active slots.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module missile_sched
    import missile_pkg::*;
#(
    parameter int NUM_SLOTS = c_def_num_slots,
    parameter int LIFETIME  = c_def_lifetime,
    parameter int COOLDOWN  = c_def_cooldown
) (
    input  logic                 frame_clk,
    input  logic                 Reset_n,
    input  logic [1:0]           fire_req,
    input  logic [NUM_SLOTS-1:0] slot_kill,
    output logic [1:0]           fire_gnt,
    output logic [NUM_SLOTS-1:0] launch,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic                 pool_full
);

    logic [c_cd_w-1:0]    cd_q [2];
    logic [c_cd_w-1:0]    cd_d [2];
    player_t              rr_q, rr_d;
    logic [1:0]           fire_gnt_q, fire_gnt_d;

    logic [NUM_SLOTS-1:0] w_free, w_first, w_rest, w_second;
    logic [NUM_SLOTS-1:0] w_p0_slot, w_p1_slot, w_slot_grant;
    logic [1:0]           w_cap_ok, w_elig;

    // Free set comes only from registered slot state; isolate lowest two free bits.
    assign w_free   = ~slot_active;
    assign w_first  = w_free & (~w_free + NUM_SLOTS'(1));
    assign w_rest   = w_free & ~w_first;
    assign w_second = w_rest & (~w_rest + NUM_SLOTS'(1));

`ifdef MISSILE_SCHED_PLAYER_CAP_EN
    logic [3:0] w_own_cnt0, w_own_cnt1;

    always_comb begin
        w_own_cnt0 = '0;
        w_own_cnt1 = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_active[i]) begin
                if (slot_owner[i]) begin
                    w_own_cnt1 = w_own_cnt1 + 4'd1;
                end else begin
                    w_own_cnt0 = w_own_cnt0 + 4'd1;
                end
            end
        end
        w_cap_ok[0] = (w_own_cnt0 < 4'(NUM_SLOTS / 2));
        w_cap_ok[1] = (w_own_cnt1 < 4'(NUM_SLOTS / 2));
    end
`else
    assign w_cap_ok = 2'b11;
`endif

    assign w_elig[0] = fire_req[0] & (cd_q[0] == '0) & w_cap_ok[0] & (|w_free);
    assign w_elig[1] = fire_req[1] & (cd_q[1] == '0) & w_cap_ok[1] & (|w_free);

    always_comb begin
        fire_gnt_d = '0;
        w_p0_slot  = '0;
        w_p1_slot  = '0;
        rr_d       = rr_q;
        case (w_elig)
            2'b01: begin
                fire_gnt_d = 2'b01;
                w_p0_slot  = w_first;
            end
            2'b10: begin
                fire_gnt_d = 2'b10;
                w_p1_slot  = w_first;
            end
            2'b11: begin
                if (|w_second) begin
                    fire_gnt_d = 2'b11;
                    w_p0_slot  = w_first;
                    w_p1_slot  = w_second;
                end else if (rr_q == PLAYER_0) begin
                    fire_gnt_d = 2'b01;
                    w_p0_slot  = w_first;
                    rr_d       = PLAYER_1;
                end else begin
                    fire_gnt_d = 2'b10;
                    w_p1_slot  = w_first;
                    rr_d       = PLAYER_0;
                end
            end
            default: ;
        endcase

        for (int p = 0; p < 2; p++) begin
            if (fire_gnt_d[p]) begin
                cd_d[p] = c_cd_w'(COOLDOWN);
            end else if (cd_q[p] != '0) begin
                cd_d[p] = cd_q[p] - c_cd_w'(1);
            end else begin
                cd_d[p] = '0;
            end
        end
    end

    assign w_slot_grant = w_p0_slot | w_p1_slot;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cd_q[0]    <= '0;
            cd_q[1]    <= '0;
            rr_q       <= PLAYER_0;
            fire_gnt_q <= '0;
        end else begin
            cd_q[0]    <= cd_d[0];
            cd_q[1]    <= cd_d[1];
            rr_q       <= rr_d;
            fire_gnt_q <= fire_gnt_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
            player_t w_gnt_owner;
            player_t w_owner;

            assign w_gnt_owner = w_p1_slot[i] ? PLAYER_1 : PLAYER_0;

            missile_slot #(
                .LIFETIME (LIFETIME)
            ) u_slot (
                .clk         (frame_clk),
                .rst_n       (Reset_n),
                .grant       (w_slot_grant[i]),
                .grant_owner (w_gnt_owner),
                .kill        (slot_kill[i]),
                .launch      (launch[i]),
                .active      (slot_active[i]),
                .owner       (w_owner)
            );

            assign slot_owner[i] = w_owner;
        end
    endgenerate

    assign fire_gnt  = fire_gnt_q;
    assign pool_full = &slot_active;

endmodule

`default_nettype wire

// File: tb/tb_missile_sched.sv
// +-----------------------------------------------------------------------------
// | Module      : tb_missile_sched
// | Description : Directed self-checking bench for missile_sched (default params).
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_missile_sched;

    logic       frame_clk;
    logic       Reset_n;
    logic [1:0] fire_req;
    logic [3:0] slot_kill;
    logic [1:0] fire_gnt;
    logic [3:0] launch;
    logic [3:0] slot_active;
    logic [3:0] slot_owner;
    logic       pool_full;

    int vec_cnt = 0;
    int err_cnt = 0;

    missile_sched dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .fire_req    (fire_req),
        .slot_kill   (slot_kill),
        .fire_gnt    (fire_gnt),
        .launch      (launch),
        .slot_active (slot_active),
        .slot_owner  (slot_owner),
        .pool_full   (pool_full)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        Reset_n   = 1'b0;
        fire_req  = 2'b00;
        slot_kill = 4'b0000;
        step();
        vec_cnt++;
        if ({fire_gnt, launch, slot_active, slot_owner, pool_full} !== 15'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {fire_gnt, launch, slot_active, slot_owner, pool_full});
        end
        step();
        Reset_n = 1'b1;
        step();
        vec_cnt++;
        if ({fire_gnt, launch, slot_active, pool_full} !== 11'd0) begin
            err_cnt++;
            $display("FAIL reset_release: got %b, want all zero",
                     {fire_gnt, launch, slot_active, pool_full});
        end
    endtask

    task automatic test_single();
        int n;
        fire_req = 2'b01;
        step();
        fire_req = 2'b00;
        vec_cnt++;
        if (fire_gnt !== 2'b01 || launch !== 4'b0001 || slot_active !== 4'b0001 || slot_owner[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_grant: gnt=%b launch=%b active=%b owner=%b, want 01 0001 0001 owner0=0",
                     fire_gnt, launch, slot_active, slot_owner);
        end
        step();
        vec_cnt++;
        if (fire_gnt !== 2'b00 || launch !== 4'b0000 || slot_active !== 4'b0001) begin
            err_cnt++;
            $display("FAIL single_pulse_end: gnt=%b launch=%b active=%b, want 00 0000 0001",
                     fire_gnt, launch, slot_active);
        end
        n = 2;
        for (int k = 0; k < 200; k++) begin
            step();
            if (slot_active[0]) n++;
            else break;
        end
        vec_cnt++;
        if (n !== 62) begin
            err_cnt++;
            $display("FAIL single_lifetime: active cycles=%0d, want 62", n);
        end
    endtask

    task automatic test_held();
        fire_req = 2'b01;
        for (int i = 1; i <= 40; i++) begin
            logic [1:0] eg;
            logic [3:0] el;
            logic       ef;
            step();
            eg = 2'b00;
            el = 4'b0000;
            case (i)
                1:  begin eg = 2'b01; el = 4'b0001; end
                10: begin eg = 2'b01; el = 4'b0010; end
                19: begin eg = 2'b01; el = 4'b0100; end
                28: begin eg = 2'b01; el = 4'b1000; end
                default: ;
            endcase
            ef = (i >= 28);
            vec_cnt++;
            if (fire_gnt !== eg || launch !== el || pool_full !== ef) begin
                err_cnt++;
                $display("FAIL held_cycle%0d: gnt=%b launch=%b full=%b, want %b %b %b",
                         i, fire_gnt, launch, pool_full, eg, el, ef);
            end
        end
        fire_req  = 2'b00;
        slot_kill = 4'b1111;
        step();
        slot_kill = 4'b0000;
        vec_cnt++;
        if (slot_active !== 4'b0000 || pool_full !== 1'b0) begin
            err_cnt++;
            $display("FAIL held_kill_all: active=%b full=%b, want 0000 0", slot_active, pool_full);
        end
    endtask

    task automatic test_contention();
        fire_req = 2'b11;
        step();
        fire_req = 2'b00;
        vec_cnt++;
        if (fire_gnt !== 2'b11 || launch !== 4'b0011 || slot_owner[1:0] !== 2'b10) begin
            err_cnt++;
            $display("FAIL both_two_free: gnt=%b launch=%b owner=%b, want 11 0011 xx10",
                     fire_gnt, launch, slot_owner);
        end
        step_n(9);
        fire_req = 2'b01;
        step();
        fire_req = 2'b00;
        vec_cnt++;
        if (fire_gnt !== 2'b01 || launch !== 4'b0100) begin
            err_cnt++;
            $display("FAIL third_slot: gnt=%b launch=%b, want 01 0100", fire_gnt, launch);
        end
        step_n(9);
        fire_req = 2'b11;
        step();
        fire_req = 2'b00;
        vec_cnt++;
        if (fire_gnt !== 2'b01 || launch !== 4'b1000 || pool_full !== 1'b1) begin
            err_cnt++;
            $display("FAIL contend_rr0: gnt=%b launch=%b full=%b, want 01 1000 1",
                     fire_gnt, launch, pool_full);
        end
        slot_kill = 4'b0010;
        step();
        slot_kill = 4'b0000;
        vec_cnt++;
        if (slot_active !== 4'b1101) begin
            err_cnt++;
            $display("FAIL kill_flight: active=%b, want 1101", slot_active);
        end
        slot_kill = 4'b0010;
        step();
        slot_kill = 4'b0000;
        vec_cnt++;
        if (slot_active !== 4'b1101 || fire_gnt !== 2'b00) begin
            err_cnt++;
            $display("FAIL kill_idle: active=%b gnt=%b, want 1101 00", slot_active, fire_gnt);
        end
        step_n(8);
        fire_req = 2'b11;
        step();
        fire_req = 2'b00;
        vec_cnt++;
        if (fire_gnt !== 2'b10 || launch !== 4'b0010 || slot_owner[1] !== 1'b1 || pool_full !== 1'b1) begin
            err_cnt++;
            $display("FAIL contend_rr1: gnt=%b launch=%b owner=%b full=%b, want 10 0010 owner1=1 1",
                     fire_gnt, launch, slot_owner, pool_full);
        end
    endtask

    task automatic test_free_latency();
        fire_req  = 2'b01;
        slot_kill = 4'b0100;
        step();
        slot_kill = 4'b0000;
        vec_cnt++;
        if (slot_active !== 4'b1011 || fire_gnt !== 2'b00 || launch !== 4'b0000) begin
            err_cnt++;
            $display("FAIL freed_not_same_edge: active=%b gnt=%b launch=%b, want 1011 00 0000",
                     slot_active, fire_gnt, launch);
        end
        step();
        fire_req = 2'b00;
        vec_cnt++;
        if (fire_gnt !== 2'b01 || launch !== 4'b0100 || slot_active !== 4'b1111) begin
            err_cnt++;
            $display("FAIL freed_next_edge: gnt=%b launch=%b active=%b, want 01 0100 1111",
                     fire_gnt, launch, slot_active);
        end
    endtask

    task automatic test_reset_mid();
        #2;
        Reset_n = 1'b0;
        #1;
        vec_cnt++;
        if ({fire_gnt, launch, slot_active, slot_owner, pool_full} !== 15'd0) begin
            err_cnt++;
            $display("FAIL reset_async: got %b, want all zero",
                     {fire_gnt, launch, slot_active, slot_owner, pool_full});
        end
        step();
        Reset_n = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            vec_cnt++;
            if (fire_gnt !== 2'b00 || launch !== 4'b0000 || slot_active !== 4'b0000 || pool_full !== 1'b0) begin
                err_cnt++;
                $display("FAIL reset_after%0d: gnt=%b launch=%b active=%b full=%b, want all zero",
                         i, fire_gnt, launch, slot_active, pool_full);
            end
        end
    endtask

`ifdef MISSILE_SCHED_PLAYER_CAP_EN
    task automatic test_cap();
        fire_req = 2'b01;
        for (int i = 1; i <= 30; i++) begin
            logic [3:0] el;
            step();
            el = (i == 1) ? 4'b0001 : (i == 10) ? 4'b0010 : 4'b0000;
            vec_cnt++;
            if (launch !== el || fire_gnt[1] !== 1'b0 || fire_gnt[0] !== (el != 4'b0000)) begin
                err_cnt++;
                $display("FAIL cap_cycle%0d: gnt=%b launch=%b, want launch %b", i, fire_gnt, launch, el);
            end
        end
        fire_req = 2'b10;
        step();
        fire_req = 2'b00;
        vec_cnt++;
        if (fire_gnt !== 2'b10 || launch !== 4'b0100) begin
            err_cnt++;
            $display("FAIL cap_p1: gnt=%b launch=%b, want 10 0100", fire_gnt, launch);
        end
        slot_kill = 4'b1111;
        step();
        slot_kill = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_held();
        test_contention();
        test_free_latency();
        test_reset_mid();
`ifdef MISSILE_SCHED_PLAYER_CAP_EN
        test_cap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
